// File: rtl/tx_block_gearbox.sv
// TX gearbox: packs 66-bit coded blocks (MSB first) into a continuous NB_OUT-bit word stream,
// with valid/ready backpressure upstream and a single-bit slip for receiver relock testing.
module tx_block_gearbox #(
   parameter int NB_CODED_BLOCK = 66,
   parameter int NB_OUT         = 64,
   parameter int NB_BUF         = NB_CODED_BLOCK + NB_OUT - 1,
   parameter int NB_FILL        = $clog2(NB_BUF + 1)
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_enable,
   input  logic [NB_CODED_BLOCK-1:0] i_data,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_slip,
   output logic [NB_OUT-1:0]         o_data,
   output logic                      o_valid,
   output logic                      o_underflow,
   output logic [NB_FILL-1:0]        o_fill
);

   localparam logic [NB_FILL:0] OUT_W = (NB_FILL+1)'(NB_OUT);
   localparam logic [NB_FILL:0] BLK_W = (NB_FILL+1)'(NB_CODED_BLOCK);
   localparam logic [NB_FILL:0] BUF_W = (NB_FILL+1)'(NB_BUF);

   logic [NB_BUF-1:0]  buf_q, buf_d, buf_out, buf_slip, blk_ext;
   logic [NB_FILL-1:0] fill_q, fill_d;
   logic [NB_OUT-1:0]  data_q;
   logic               valid_q, underflow_q;
   logic [NB_FILL:0]   fill_x, fill_out, fill_slip;
   logic               out_fire, slip_ok, accept;

   // One extra bit of headroom so fill + block never wraps in the ready test.
   assign fill_x   = {1'b0, fill_q};
   assign out_fire = (fill_x >= OUT_W);
   assign fill_out = out_fire ? fill_x - OUT_W : fill_x;
   assign o_ready  = i_reset_n & i_enable & ((fill_out + BLK_W) <= BUF_W);

   always_comb begin
      buf_out   = out_fire ? (buf_q << NB_OUT) : buf_q;
      slip_ok   = i_slip && (fill_out != '0);
      buf_slip  = slip_ok ? (buf_out << 1) : buf_out;
      fill_slip = fill_out - {{NB_FILL{1'b0}}, slip_ok};
      blk_ext   = '0;
      blk_ext[NB_BUF-1 -: NB_CODED_BLOCK] = i_data;
      accept    = i_valid && o_ready;
      // Bits below fill are always zero, so the new block can be OR-ed in at the tail.
      buf_d     = accept ? (buf_slip | (blk_ext >> fill_slip)) : buf_slip;
      fill_d    = NB_FILL'(accept ? fill_slip + BLK_W : fill_slip);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         buf_q       <= '0;
         fill_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else if (i_enable) begin
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         valid_q     <= out_fire;
         underflow_q <= !out_fire;
         if (out_fire) data_q <= buf_q[NB_BUF-1 -: NB_OUT];
      end else begin
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_underflow = underflow_q;
   assign o_fill      = fill_q;

endmodule

// File: tb/tb_tx_block_gearbox.sv
// Bench for tx_block_gearbox: random blocks against a bit-queue reference of the line stream.
module tb_tx_block_gearbox;

   logic        clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_enable = 1'b0;
   logic [65:0] i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_slip = 1'b0;
   logic [63:0] o_data;
   logic        o_valid;
   logic        o_underflow;
   logic [7:0]  o_fill;

   tx_block_gearbox dut (
      .i_clock(clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
      .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .i_slip(i_slip),
      .o_data(o_data), .o_valid(o_valid), .o_underflow(o_underflow), .o_fill(o_fill)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: the pending line bits, oldest first.
   bit          mq[$];
   logic [63:0] exp_data;
   logic        exp_valid, exp_unf, exp_rdy, acc, rdy_seen;
   logic [7:0]  exp_fill;
   logic [65:0] cur;
   logic [31:0] blk_cnt = 0;
   int          cyc = 0;

   task automatic next_blk();
      cur = {2'b01, blk_cnt, $urandom()};
      blk_cnt++;
   endtask

   task automatic model_clear();
      mq.delete();
      exp_data = '0; exp_valid = 0; exp_unf = 0; exp_fill = 0; exp_rdy = 0;
   endtask

   task automatic do_reset();
      i_reset_n = 0; i_enable = 1; i_valid = 0; i_slip = 0;
      @(posedge clk); #1;
      i_reset_n = 1;
      model_clear();
   endtask

   // Drives one clock cycle and advances the reference model; returns 1 ns after the edge.
   task automatic drive_cycle(input logic en, input logic v, input logic [65:0] d, input logic s);
      int after;
      i_enable = en; i_valid = v; i_data = d; i_slip = s;
      #1;
      rdy_seen = o_ready;
      acc = 0;
      if (!en) begin
         exp_rdy = 0; exp_valid = 0; exp_unf = 0;
      end else begin
         after   = (mq.size() >= 64) ? mq.size() - 64 : mq.size();
         exp_rdy = (after + 66 <= 129);
         if (mq.size() >= 64) begin
            for (int i = 0; i < 64; i++) exp_data = {exp_data[62:0], mq.pop_front()};
            exp_valid = 1; exp_unf = 0;
         end else begin
            exp_valid = 0; exp_unf = 1;
         end
         if (s && mq.size() > 0) void'(mq.pop_front());
         if (v && exp_rdy) begin
            acc = 1;
            for (int i = 65; i >= 0; i--) mq.push_back(d[i]);
         end
      end
      exp_fill = 8'(mq.size());
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic test_reset();
      i_reset_n = 0; i_enable = 1; i_valid = 1; i_data = '1;
      #3;
      tests++;
      if ({o_ready, o_valid, o_underflow, o_fill, o_data} !== '0) begin
         fails++;
         $display("FAIL reset_state: got rdy=%0b v=%0b u=%0b fill=%0d data=%h, want all 0",
                  o_ready, o_valid, o_underflow, o_fill, o_data);
      end
      do_reset();
   endtask

   task automatic test_slip_empty();
      logic [65:0] b0;
      logic        seen;
      do_reset();
      drive_cycle(1, 0, cur, 1);
      tests++;
      if (o_fill !== 8'd0 || o_underflow !== 1'b1 || o_valid !== 1'b0) begin
         fails++;
         $display("FAIL slip_empty: got fill=%0d u=%0b v=%0b, want fill=0 u=1 v=0", o_fill, o_underflow, o_valid);
      end
      b0 = cur; seen = 0;
      for (int k = 0; k < 40; k++) begin
         drive_cycle(1, 1, cur, 0);
         if (acc) next_blk();
         tests++;
         if ({o_valid, o_underflow, o_fill, rdy_seen, o_data} !== {exp_valid, exp_unf, exp_fill, exp_rdy, exp_data}) begin
            fails++;
            $display("FAIL slip_empty_stream cyc %0d: got v=%0b u=%0b fill=%0d rdy=%0b d=%h, want v=%0b u=%0b fill=%0d rdy=%0b d=%h",
                     cyc, o_valid, o_underflow, o_fill, rdy_seen, o_data, exp_valid, exp_unf, exp_fill, exp_rdy, exp_data);
         end
         if (o_valid && !seen) begin
            seen = 1; tests++;
            if (o_data !== b0[65:2]) begin
               fails++;
               $display("FAIL slip_empty_first_word: got %h, want %h", o_data, b0[65:2]);
            end
         end
      end
   endtask

   task automatic test_stream();
      int first_acc, first_vld, last_low, lows, gap_bad, vld_miss, nacc, k;
      do_reset();
      first_acc = -1; first_vld = -1; last_low = -1; lows = 0; gap_bad = 0; vld_miss = 0; nacc = 0; k = 0;
      while (nacc < 10000 && k < 20000) begin
         drive_cycle(1, 1, cur, 0);
         if (acc) begin nacc++; next_blk(); end
         tests++;
         if ({o_valid, o_underflow, o_fill, rdy_seen, o_data} !== {exp_valid, exp_unf, exp_fill, exp_rdy, exp_data}) begin
            fails++;
            $display("FAIL stream cyc %0d: got v=%0b u=%0b fill=%0d rdy=%0b d=%h, want v=%0b u=%0b fill=%0d rdy=%0b d=%h",
                     cyc, o_valid, o_underflow, o_fill, rdy_seen, o_data, exp_valid, exp_unf, exp_fill, exp_rdy, exp_data);
         end
         if (acc && first_acc < 0) first_acc = k;
         if (o_valid === 1'b1 && first_vld < 0) first_vld = k;
         if (k >= 200) begin
            if (rdy_seen !== 1'b1) begin
               if (last_low >= 0 && k - last_low != 33) gap_bad++;
               last_low = k; lows++;
            end
            if (o_valid !== 1'b1) vld_miss++;
         end
         k++;
      end
      tests++;
      if (first_vld != first_acc + 1) begin
         fails++;
         $display("FAIL first_valid_latency: got valid at cycle %0d, want %0d", first_vld, first_acc + 1);
      end
      tests++;
      if (gap_bad != 0 || lows < 100) begin
         fails++;
         $display("FAIL ready_period: got %0d bad gaps over %0d low cycles, want 0 bad and >=100 lows", gap_bad, lows);
      end
      tests++;
      if (vld_miss != 0) begin
         fails++;
         $display("FAIL steady_valid: got %0d cycles without o_valid, want 0", vld_miss);
      end
   endtask

   task automatic test_slip();
      for (int k = 0; k < 200; k++) begin
         drive_cycle(1, 1, cur, k == 40);
         if (acc) next_blk();
         tests++;
         if ({o_valid, o_underflow, o_fill, rdy_seen, o_data} !== {exp_valid, exp_unf, exp_fill, exp_rdy, exp_data}) begin
            fails++;
            $display("FAIL slip cyc %0d: got v=%0b u=%0b fill=%0d rdy=%0b d=%h, want v=%0b u=%0b fill=%0d rdy=%0b d=%h",
                     cyc, o_valid, o_underflow, o_fill, rdy_seen, o_data, exp_valid, exp_unf, exp_fill, exp_rdy, exp_data);
         end
      end
   endtask

   task automatic test_stall();
      int uf;
      uf = 0;
      for (int k = 0; k < 105; k++) begin
         drive_cycle(1, !(k >= 10 && k < 15), cur, 0);
         if (acc) next_blk();
         if (o_underflow === 1'b1) uf++;
         tests++;
         if ({o_valid, o_underflow, o_fill, rdy_seen, o_data} !== {exp_valid, exp_unf, exp_fill, exp_rdy, exp_data}) begin
            fails++;
            $display("FAIL stall cyc %0d: got v=%0b u=%0b fill=%0d rdy=%0b d=%h, want v=%0b u=%0b fill=%0d rdy=%0b d=%h",
                     cyc, o_valid, o_underflow, o_fill, rdy_seen, o_data, exp_valid, exp_unf, exp_fill, exp_rdy, exp_data);
         end
      end
      tests++;
      if (uf == 0) begin
         fails++;
         $display("FAIL stall_underflow: got %0d underflow cycles, want >0", uf);
      end
   endtask

   task automatic test_enable();
      for (int k = 0; k < 80; k++) begin
         if (k >= 20 && k < 27) drive_cycle(0, 1, cur, 1);
         else drive_cycle(1, 1, cur, 0);
         if (acc) next_blk();
         tests++;
         if ({o_valid, o_underflow, o_fill, rdy_seen, o_data} !== {exp_valid, exp_unf, exp_fill, exp_rdy, exp_data}) begin
            fails++;
            $display("FAIL enable cyc %0d: got v=%0b u=%0b fill=%0d rdy=%0b d=%h, want v=%0b u=%0b fill=%0d rdy=%0b d=%h",
                     cyc, o_valid, o_underflow, o_fill, rdy_seen, o_data, exp_valid, exp_unf, exp_fill, exp_rdy, exp_data);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [65:0] b;
      for (int k = 0; k < 13; k++) begin
         drive_cycle(1, 1, cur, 0);
         if (acc) next_blk();
      end
      #3;
      i_reset_n = 0;
      #1;
      tests++;
      if ({o_ready, o_valid, o_underflow, o_fill, o_data} !== '0) begin
         fails++;
         $display("FAIL async_reset: got rdy=%0b v=%0b u=%0b fill=%0d data=%h, want all 0",
                  o_ready, o_valid, o_underflow, o_fill, o_data);
      end
      @(posedge clk); #1;
      i_reset_n = 1;
      model_clear();
      next_blk();
      b = cur;
      drive_cycle(1, 1, b, 0);
      next_blk();
      drive_cycle(1, 0, cur, 0);
      tests++;
      if (o_valid !== 1'b1 || o_data !== b[65:2]) begin
         fails++;
         $display("FAIL post_reset_word: got v=%0b d=%h, want v=1 d=%h", o_valid, o_data, b[65:2]);
      end
   endtask

   initial begin
      next_blk();
      test_reset();
      test_slip_empty();
      test_stream();
      test_slip();
      test_stall();
      test_enable();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
